// File: rtl/corr_search_ctrl.sv
// corr_search_ctrl: walks a rectangular window of candidate start positions
// in raster order (X inner), launches the correlation scorer at each one and
// keeps the highest score together with the position where it first occurred.
//
// Scorer handshake (pulse protocol, no backpressure): oCorrStart is a
// one-cycle pulse issued while oXstart/oYstart already hold the candidate; the
// scorer answers with a one-cycle iCorrDone carrying iCorrScore in that same
// cycle. Only a done seen in WAIT is accepted; any other done is dropped.
// iStart is a one-cycle request honoured only in IDLE; oDone is a one-cycle
// completion pulse.
module corr_search_ctrl #(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 640,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 480,
  parameter int X_STEP  = 1,
  parameter int Y_STEP  = 1,
  parameter int TIMEOUT = 1048575
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iStart,
  output logic        oBusy,
  output logic        oDone,
  output logic [12:0] oXstart,
  output logic [12:0] oYstart,
  output logic        oCorrStart,
  input  logic        iCorrDone,
  input  logic [31:0] iCorrScore,
  output logic [31:0] oBestScore,
  output logic [12:0] oBestX,
  output logic [12:0] oBestY,
  output logic        oTimeout,
  output logic [2:0]  oDbgState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_EVAL    = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [12:0]   X_MIN_C  = 13'(X_MIN);
  localparam logic [12:0]   Y_MIN_C  = 13'(Y_MIN);
  // Wide (14-bit) bounds so a step past 8191 cannot wrap back into range.
  localparam logic [13:0]   X_MAX_W  = 14'(X_MAX);
  localparam logic [13:0]   Y_MAX_W  = 14'(Y_MAX);
  localparam logic [13:0]   X_STEP_W = 14'(X_STEP);
  localparam logic [13:0]   Y_STEP_W = 14'(Y_STEP);
  localparam logic [CW-1:0] TMO_C    = CW'(TIMEOUT);

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          corr_start_q;
  logic [12:0]   x_q;
  logic [12:0]   y_q;
  logic [31:0]   score_q;
  logic [31:0]   best_q;
  logic [12:0]   best_x_q;
  logic [12:0]   best_y_q;
  logic          tmo_q;
  logic [CW-1:0] cnt_q;

  logic [13:0]   x_sum_d;
  logic [13:0]   y_sum_d;

  // Candidate next positions, widened by one bit for the range test.
  always_comb begin
    x_sum_d = {1'b0, x_q} + X_STEP_W;
    y_sum_d = {1'b0, y_q} + Y_STEP_W;
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      corr_start_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      score_q      <= '0;
      best_q       <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            x_q          <= X_MIN_C;
            y_q          <= Y_MIN_C;
            best_q       <= '0;
            best_x_q     <= X_MIN_C;
            best_y_q     <= Y_MIN_C;
            tmo_q        <= 1'b0;
            busy_q       <= 1'b1;
            corr_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          corr_start_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // A real answer wins over a timeout landing in the same cycle.
          if (iCorrDone) begin
            score_q <= iCorrScore;
            state_q <= S_EVAL;
          end else if (cnt_q == TMO_C) begin
            score_q <= '0;
            tmo_q   <= 1'b1;
            state_q <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_EVAL: begin
          // Strictly greater: ties keep the earliest position.
          if (score_q > best_q) begin
            best_q   <= score_q;
            best_x_q <= x_q;
            best_y_q <= y_q;
          end
          state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (x_sum_d <= X_MAX_W) begin
            x_q          <= x_sum_d[12:0];
            corr_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end else if (y_sum_d <= Y_MAX_W) begin
            x_q          <= X_MIN_C;
            y_q          <= y_sum_d[12:0];
            corr_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oXstart    = x_q;
  assign oYstart    = y_q;
  assign oCorrStart = corr_start_q;
  assign oBestScore = best_q;
  assign oBestX     = best_x_q;
  assign oBestY     = best_y_q;
  assign oTimeout   = tmo_q;
  assign oDbgState  = state_q;

endmodule

// File: doc/corr_search_ctrl.md
Name: corr_search_ctrl

Overview:
- Sequences the correlation scorer across a rectangular window of candidate start positions.
- Per position: presents oXstart/oYstart, pulses a start, waits for the scorer's done pulse and 32-bit score.
- Tracks the maximum score and the position where it occurs.
- Sits between the capture/search top level (issues iStart, consumes best match) and the scorer datapath.

Parameters:
- X_MIN, 0, first candidate X start (13-bit).
- X_MAX, 640, last permissible candidate X start (inclusive).
- Y_MIN, 0, first candidate Y start.
- Y_MAX, 480, last permissible candidate Y start (inclusive).
- X_STEP, 1, X increment between candidates (>=1).
- Y_STEP, 1, Y increment between candidate rows (>=1).
- TIMEOUT, 1048575, max cycles to wait for iCorrDone per position.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  synchronous active-low reset.
- iStart  in  1  pulse: begin a full window sweep.
- oBusy  out  1  high from accepted iStart until oDone.
- oDone  out  1  one-cycle pulse when the sweep completes.
- oXstart  out  13  candidate X start presented to the scorer.
- oYstart  out  13  candidate Y start presented to the scorer.
- oCorrStart  out  1  one-cycle pulse: scorer begins at oXstart/oYstart.
- iCorrDone  in  1  one-cycle pulse from the scorer: iCorrScore valid.
- iCorrScore  in  32  correlation score, unsigned.
- oBestScore  out  32  highest score seen in current/last sweep.
- oBestX  out  13  X start of oBestScore.
- oBestY  out  13  Y start of oBestScore.
- oTimeout  out  1  sticky: some position timed out this sweep.

Behaviour:
- Reset (iRST_N=0 at posedge): state IDLE. All outputs 0. Internal timeout counter 0. Reset mid-sweep aborts immediately; the scorer is not notified.
- States: IDLE, LAUNCH, WAIT, EVAL, ADVANCE, FINISH.
- IDLE → LAUNCH on iStart=1:
  - oXstart=X_MIN, oYstart=Y_MIN.
  - oBestScore=0, oBestX=X_MIN, oBestY=Y_MIN, oTimeout=0.
  - oBusy=1 from the next cycle.
- iStart is ignored while oBusy=1.
- LAUNCH: oCorrStart=1 for exactly this cycle; clear timeout counter; → WAIT.
  - oXstart/oYstart stay stable from LAUNCH until leaving EVAL.
- WAIT:
  - iCorrDone=1: latch iCorrScore; → EVAL.
  - Counter reaches TIMEOUT: latched score = 0, set oTimeout; → EVAL.
  - Timeout counter increments each WAIT cycle.
- EVAL: if latched score > oBestScore (strictly), update oBestScore/oBestX/oBestY to the current position. Ties keep the earliest position. → ADVANCE.
- ADVANCE, raster order, X inner:
  - If oXstart+X_STEP <= X_MAX: X += X_STEP; → LAUNCH.
  - Else if oYstart+Y_STEP <= Y_MAX: X = X_MIN, Y += Y_STEP; → LAUNCH.
  - Else → FINISH.
  - Comparisons use 14-bit sums so 13-bit overflow cannot wrap into range.
- FINISH: oDone=1 for one cycle, oBusy=0; → IDLE.
  - oBest* and oTimeout hold until the next accepted iStart.
- iCorrDone outside WAIT is ignored.
  - Includes a late done after a timeout: it does not alter the best or the position.
- Per-position overhead: 3 controller cycles (LAUNCH, EVAL, ADVANCE) plus scorer latency.
  - Done sampled in cycle n gives EVAL at n+1 and the next oCorrStart at n+3.
- Position count = (floor((X_MAX-X_MIN)/X_STEP)+1) × (floor((Y_MAX-Y_MIN)/Y_STEP)+1).
  - X_MIN=X_MAX and Y_MIN=Y_MAX gives exactly one position.
- Score 0 on every position: best stays 0 at (X_MIN,Y_MIN).

Test Plan:
- Window X 0..2, Y 0..1, step 1; scorer model returns done 5 cycles after start with score 10·X+Y → exactly 6 oCorrStart pulses in order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); oDone once; oBestScore=21, oBestX=2, oBestY=1.
- Same window, scores all 7 → oBestScore=7 at (0,0) (tie keeps first); oTimeout=0.
- TIMEOUT=16, scorer never responds at (1,0), others score 5 → oTimeout=1; sweep still completes 6 positions; best=5 at (0,0); late iCorrDone with score 99 injected during EVAL is ignored.
- X 0..10 step 4, Y 0..5 step 5 → positions X∈{0,4,8}, Y∈{0,5}: 6 launches; no launch at X=12 or Y=10.
- iRST_N low for 1 cycle mid-WAIT at position 3 → next cycle all outputs 0, state IDLE; new iStart yields a clean full sweep; iStart pulsed while busy causes no restart.
